fib_sweep: RTL and testbench

Sequential sweep-and-check stage that sits directly upstream of the combinational Fibonacci detector. On `start`, it steps the detector input `x` through every N-bit value, 0 to 2^N−1. For each value it samples the detector's `is_fib` response and compares it with a reference Fibonacci sequence generated internally with an adder pair. It reports a mismatch count, the first failing input, and pass/done status, so the detector can be checked on-chip or in simulation without a hand-written golden table.

---
 rtl/fib_pkg.sv | 14 +
 rtl/fib_gen.sv | 36 +++
 rtl/fib_sweep.sv | 99 +++++++++
 tb/tb_fib_sweep.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci detector sweep stage.
package fib_pkg;

    localparam int unsigned N_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/fib_gen.sv
// Reference Fibonacci pair (a, b) with an a <= x compare for the sweep FSM.
module fib_gen
    import fib_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic         step,
    input  logic [N-1:0] x,
    output logic [N+1:0] a,
    output logic         le_x
);

    localparam int unsigned AW = N + 2;

    logic [AW-1:0] b;

    // Two guard bits keep a + b exact; the pair stops stepping once a >= 2^N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= '0;
            b <= AW'(1);
        end else if (init) begin
            a <= '0;
            b <= AW'(1);
        end else if (step) begin
            a <= b;
            b <= a + b;
        end
    end

    assign le_x = (a <= AW'(x));

endmodule

// File: rtl/fib_sweep.sv
// Sweeps the detector input over 0..2^N-1 and scores is_fib against fib_gen.
module fib_sweep
    import fib_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_fib,
    output logic [N-1:0] x,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt,
    output logic [N-1:0] first_err
);

    localparam int unsigned AW = N + 2;
    localparam int unsigned CW = N + 1;

    state_t        state;
    logic [AW-1:0] a;
    logic          le_x;
    logic          init_c;
    logic          step_c;
    logic          exp_c;

    assign init_c = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign step_c = (state == ST_ADVANCE) && le_x;
    assign exp_c  = (a == AW'(x));

    fib_gen #(.N(N)) u_fib_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (init_c),
        .step  (step_c),
        .x     (x),
        .a     (a),
        .le_x  (le_x)
    );

    // Sweep FSM, x counter and error bookkeeping; x moves only when leaving ADVANCE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            x         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            first_err <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        x         <= '0;
                        err_cnt   <= '0;
                        first_err <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        state     <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (is_fib != exp_c) begin
                        err_cnt <= err_cnt + CW'(1);
                        if (err_cnt == '0) begin
                            first_err <= x;
                        end
                    end
                    state <= ST_ADVANCE;
                end
                ST_ADVANCE: begin
                    // Stay here while the pair still needs stepping past x.
                    if (!le_x) begin
                        if (&x) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_cnt == '0);
                            state <= ST_DONE;
                        end else begin
                            x     <= x + N'(1);
                            state <= ST_DRIVE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_sweep.sv
// Scoreboard bench: each sweep pushes its expected result; a monitor checks it when done rises.
module tb_fib_sweep;
    import fib_pkg::*;

    localparam int N = 4;
    localparam int NV = 16;
    localparam int LAT = 56;

    typedef struct {
        int err;
        int first;
        int pass;
        int start_cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         is_fib;
    logic [N-1:0] x;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_cnt;
    logic [N-1:0] first_err;

    logic [NV-1:0] fib_ref;
    logic [NV-1:0] mask;
    exp_t          sb[$];
    exp_t          mon_e;
    int            cyc;
    int            n_checks;
    int            n_fail;
    logic          done_q;

    fib_sweep #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_fib    (is_fib),
        .x         (x),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .first_err (first_err)
    );

    // Detector stand-in: correct answer flipped wherever mask has a 1.
    assign is_fib = fib_ref[x] ^ mask[x];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: fault mask mapped straight to mismatch count and first failing x.
    function automatic exp_t model(input logic [NV-1:0] m, input int sc);
        exp_t e;
        e.err = 0;
        e.first = 0;
        for (int v = NV - 1; v >= 0; v--) begin
            if (m[v]) begin
                e.err++;
                e.first = v;
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        e.start_cyc = sc;
        return e;
    endfunction

    // Monitor: pops one expectation on each rising edge of done.
    always @(negedge clk) begin
        done_q <= done;
        if (rst_n && done && !done_q) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("err_cnt", int'(err_cnt), mon_e.err);
                check("first_err", (mon_e.err != 0) ? int'(first_err) : mon_e.first, mon_e.first);
                check("pass", int'(pass), mon_e.pass);
                check("busy_at_done", int'(busy), 0);
                check("done_latency", cyc - mon_e.start_cyc, LAT);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_sweep(input logic [NV-1:0] m, input bit poke_busy);
        int k;
        mask = m;
        pulse_start();
        sb.push_back(model(m, cyc));
        check("busy_after_start", int'(busy), 1);
        check("err_cleared", int'(err_cnt), 0);
        check("done_cleared", int'(done), 0);
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
            if (poke_busy && (k == 4 || k == 29)) start = 1'b1;
            else start = 1'b0;
        end
        start = 1'b0;
        if (!done) begin
            check("done_timeout", 0, 1);
            void'(sb.pop_front());
        end
        repeat (3) @(negedge clk);
        check("done_held", int'(done), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, int'(x), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_err_cnt"}, int'(err_cnt), 0);
        check({tag, "_first_err"}, int'(first_err), 0);
        check({tag, "_state"}, int'(dut.state), int'(ST_IDLE));
    endtask

    initial begin
        int a0;
        int b0;
        int t;
        int s;
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        done_q = 1'b0;
        start = 1'b0;
        mask = '0;
        rst_n = 1'b0;

        fib_ref = '0;
        a0 = 0;
        b0 = 1;
        while (a0 < NV) begin
            fib_ref[a0] = 1'b1;
            t = a0 + b0;
            a0 = b0;
            b0 = t;
        end

        #22;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep('0, 1'b0);                        // correct detector
        run_sweep(fib_ref, 1'b0);                   // is_fib tied low
        run_sweep(16'hFFFF, 1'b0);                  // inverted detector
        run_sweep(16'h0010, 1'b0);                  // single fault at x = 4
        run_sweep('0, 1'b1);                        // start pulses while busy

        // Reset mid-sweep: outputs clear before the next clock edge.
        mask = 16'h0003;
        pulse_start();
        s = cyc;
        while (cyc - s < 20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep('0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run_sweep(NV'($urandom), 1'b0);          // restarts from DONE each time
        end
        run_sweep('0, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
